// File: rtl/link_pattern_aligner_pkg.sv
// Shared definitions for the link pattern aligner: state encodings, word geometry
// and small helpers used by the top and the PRBS7 word checker.
package link_pattern_aligner_pkg;

    // Deserializer word width; bit 39 is first on the wire.
    localparam int unsigned LPA_WORD_BITS  = 40;
    // Bits of the word compared against the fixed pattern (word[39:8]).
    localparam int unsigned LPA_FIXED_BITS = 32;
    // Deserializer word delay is 0..LPA_WORD_BITS-1.
    localparam int unsigned LPA_DELAY_W    = 6;
    // Width of a per-word bit-error count (0..40).
    localparam int unsigned LPA_ERRS_W     = 6;

    typedef enum logic [1:0] {
        LPA_IDLE    = 2'b00,
        LPA_SEARCH  = 2'b01,
        LPA_CONFIRM = 2'b10,
        LPA_LOCKED  = 2'b11
    } lpaState_e;

    // Next word-boundary delay; wraps from the last bit position back to 0.
    function automatic logic [LPA_DELAY_W-1:0] nextDelay(input logic [LPA_DELAY_W-1:0] cur);
        if (cur >= LPA_DELAY_W'(LPA_WORD_BITS - 1)) begin
            return '0;
        end
        return cur + LPA_DELAY_W'(1);
    endfunction

    // Number of set bits in a word-wide mismatch vector.
    function automatic logic [LPA_ERRS_W-1:0] popCount40(input logic [LPA_WORD_BITS-1:0] v);
        logic [LPA_ERRS_W-1:0] n;
        n = '0;
        for (int i = 0; i < LPA_WORD_BITS; i++) begin
            n = n + {{(LPA_ERRS_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs7_word_checker.sv
// Combinational PRBS7 (x^7 + x^6 + 1) checker for one 40-bit deserialized word.
// Self-synchronising: each bit is predicted from the bits 7 and 6 positions earlier
// in serial order, with the 7 LSBs of the previous word supplying the history.
// Only built when LINKCHK_PRBS7_EN is defined.
`ifdef LINKCHK_PRBS7_EN
module prbs7_word_checker
    import link_pattern_aligner_pkg::*;
(
    input  logic [LPA_WORD_BITS-1:0] word,
    input  logic [6:0]               history,
    output logic [LPA_WORD_BITS-1:0] mismatch,
    output logic [LPA_ERRS_W-1:0]    bitErrors
);

    // Serial order runs from the MSB down, so the history sits above the word.
    logic [LPA_WORD_BITS+6:0] extended;

    assign extended = {history, word};

    // Compare every received bit against its prediction b[n-7] ^ b[n-6].
    always_comb begin
        mismatch = '0;
        for (int i = 0; i < LPA_WORD_BITS; i++) begin
            mismatch[i] = word[i] ^ extended[i+7] ^ extended[i+6];
        end
    end

    assign bitErrors = popCount40(mismatch);

endmodule
`endif

// File: rtl/link_pattern_aligner.sv
// Word-alignment and link-quality checker behind the 40-bit deserializer.
// Searches for the link-reset pattern by stepping the deserializer word delay, confirms
// alignment over GOOD_COUNT words, then tracks lock and accumulates bit errors.
// Build option: define LINKCHK_PRBS7_EN to add the PRBS7 checker (patternSel selects the
// mode); otherwise only the fixed 32-bit pattern is checked and patternSel is ignored.
module link_pattern_aligner
    import link_pattern_aligner_pkg::*;
#(
    parameter int unsigned GOOD_COUNT   = 8,
    parameter int unsigned BAD_LIMIT    = 4,
    parameter int unsigned SLIP_WAIT    = 3,
    parameter int unsigned ERRCNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     patternSel,
    input  logic [LPA_FIXED_BITS-1:0] fixedPattern,
    input  logic [LPA_WORD_BITS-1:0] word40b,
    input  logic                     errClear,
    output logic [LPA_DELAY_W-1:0]   delay,
    output logic                     slip,
    output logic                     locked,
    output logic [1:0]               state,
    output logic                     wordErr,
    output logic [ERRCNT_WIDTH-1:0]  errCount
);

    localparam int unsigned SUM_W = ERRCNT_WIDTH + 1;

    lpaState_e                stateQ, stateD;
    logic [LPA_DELAY_W-1:0]   delayQ, delayD;
    logic                     slipQ, slipD;
    logic                     lockedQ, lockedD;
    logic                     wordErrQ, wordErrD;
    logic [ERRCNT_WIDTH-1:0]  errCountQ, errCountD;
    logic [7:0]               goodCntQ, goodCntD;
    logic [7:0]               badCntQ, badCntD;
    logic [7:0]               waitCntQ, waitCntD;

    logic [LPA_FIXED_BITS-1:0] fixedMismatch;
    logic                      wordMatch;
    logic [LPA_ERRS_W-1:0]     bitErrors;
    logic [SUM_W-1:0]          errSum;
    logic [ERRCNT_WIDTH-1:0]   errSat;

    assign fixedMismatch = word40b[LPA_WORD_BITS-1:LPA_WORD_BITS-LPA_FIXED_BITS] ^ fixedPattern;

`ifdef LINKCHK_PRBS7_EN
    logic [6:0]               historyQ;
    logic [LPA_WORD_BITS-1:0] prbsMismatch;
    logic [LPA_ERRS_W-1:0]    prbsErrors;

    prbs7_word_checker uPrbs7 (
        .word      (word40b),
        .history   (historyQ),
        .mismatch  (prbsMismatch),
        .bitErrors (prbsErrors)
    );

    // History tracks the wire on every word so the checker resynchronises on its own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            historyQ <= '0;
        end else begin
            historyQ <= word40b[6:0];
        end
    end

    assign wordMatch = patternSel ? (fixedMismatch == '0) : (prbsMismatch == '0);
    assign bitErrors = patternSel ? popCount40({8'd0, fixedMismatch}) : prbsErrors;
`else
    // Fixed-pattern-only build: the pad byte and the mode select have no effect.
    logic unusedInputs;
    assign unusedInputs = ^{patternSel, word40b[LPA_WORD_BITS-LPA_FIXED_BITS-1:0]};

    assign wordMatch = (fixedMismatch == '0);
    assign bitErrors = popCount40({8'd0, fixedMismatch});
`endif

    // Saturating accumulate: clamp at all-ones instead of wrapping.
    always_comb begin
        errSum = {1'b0, errCountQ} + SUM_W'(bitErrors);
        errSat = errSum[ERRCNT_WIDTH] ? '1 : errSum[ERRCNT_WIDTH-1:0];
    end

    // Next-state: enable gate, settle wait after a slip, then the search/confirm/lock rules.
    always_comb begin
        stateD    = stateQ;
        delayD    = delayQ;
        slipD     = 1'b0;
        lockedD   = lockedQ;
        wordErrD  = wordErrQ;
        errCountD = errCountQ;
        goodCntD  = goodCntQ;
        badCntD   = badCntQ;
        waitCntD  = waitCntQ;

        if (!enable) begin
            stateD   = LPA_IDLE;
            lockedD  = 1'b0;
            goodCntD = '0;
            badCntD  = '0;
            waitCntD = '0;
        end else if (stateQ == LPA_IDLE) begin
            stateD   = LPA_SEARCH;
            waitCntD = '0;
        end else if (stateQ != LPA_LOCKED && waitCntQ != '0) begin
            // Deserializer still settling after a delay step.
            waitCntD = waitCntQ - 8'd1;
        end else begin
            wordErrD = ~wordMatch;
            case (stateQ)
                LPA_SEARCH: begin
                    if (wordMatch) begin
                        stateD   = LPA_CONFIRM;
                        goodCntD = 8'd1;
                    end else begin
                        delayD   = nextDelay(delayQ);
                        slipD    = 1'b1;
                        waitCntD = 8'(SLIP_WAIT);
                    end
                end
                LPA_CONFIRM: begin
                    if (wordMatch) begin
                        if (goodCntQ + 8'd1 >= 8'(GOOD_COUNT)) begin
                            stateD   = LPA_LOCKED;
                            lockedD  = 1'b1;
                            goodCntD = '0;
                        end else begin
                            goodCntD = goodCntQ + 8'd1;
                        end
                    end else begin
                        stateD   = LPA_SEARCH;
                        goodCntD = '0;
                        delayD   = nextDelay(delayQ);
                        slipD    = 1'b1;
                        waitCntD = 8'(SLIP_WAIT);
                    end
                end
                LPA_LOCKED: begin
                    if (wordMatch) begin
                        badCntD = '0;
                    end else if (badCntQ + 8'd1 >= 8'(BAD_LIMIT)) begin
                        // Losing lock: restart the search at the current delay, no slip.
                        stateD   = LPA_SEARCH;
                        lockedD  = 1'b0;
                        badCntD  = '0;
                        waitCntD = '0;
                    end else begin
                        badCntD   = badCntQ + 8'd1;
                        errCountD = errSat;
                    end
                end
                default: begin
                    stateD = LPA_IDLE;
                end
            endcase
        end

        // Clear beats a same-cycle increment, but only while enabled.
        if (enable && errClear) begin
            errCountD = '0;
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ    <= LPA_IDLE;
            delayQ    <= '0;
            slipQ     <= 1'b0;
            lockedQ   <= 1'b0;
            wordErrQ  <= 1'b0;
            errCountQ <= '0;
            goodCntQ  <= '0;
            badCntQ   <= '0;
            waitCntQ  <= '0;
        end else begin
            stateQ    <= stateD;
            delayQ    <= delayD;
            slipQ     <= slipD;
            lockedQ   <= lockedD;
            wordErrQ  <= wordErrD;
            errCountQ <= errCountD;
            goodCntQ  <= goodCntD;
            badCntQ   <= badCntD;
            waitCntQ  <= waitCntD;
        end
    end

    assign delay    = delayQ;
    assign slip     = slipQ;
    assign locked   = lockedQ;
    assign state    = stateQ;
    assign wordErr  = wordErrQ;
    assign errCount = errCountQ;

endmodule

// File: tb/tb_link_pattern_aligner.sv
// Directed bench for link_pattern_aligner. A small deserializer model rotates a fixed
// pattern word (or walks a PRBS7 stream) according to the DUT delay output, so the word
// only lines up once the DUT has stepped to the bench's target delay.
module tb_link_pattern_aligner;

    localparam logic [31:0] FIX_PAT  = 32'h3C5C3C5A;
    localparam logic [39:0] FIX_BASE = {FIX_PAT, 8'h00};
    localparam logic [39:0] FULL_ERR = {32'hFFFF_FFFF, 8'h00};
    localparam logic [39:0] PRBS_BAD = 40'h00_00FF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        patternSel;
    logic [31:0] fixedPattern;
    logic [39:0] word40b;
    logic        errClear;
    logic [5:0]  delay;
    logic        slip;
    logic        locked;
    logic [1:0]  state;
    logic        wordErr;
    logic [15:0] errCount;

    int          vectors = 0;
    int          miscompares = 0;
    int          slipCount = 0;
    int          target = 7;
    logic        prbsMode = 1'b0;
    logic [6:0]  prbsReg = 7'h2A;
    logic [39:0] errMask = '0;

    always #5 clk = ~clk;

    link_pattern_aligner #(
        .GOOD_COUNT   (8),
        .BAD_LIMIT    (4),
        .SLIP_WAIT    (3),
        .ERRCNT_WIDTH (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .patternSel   (patternSel),
        .fixedPattern (fixedPattern),
        .word40b      (word40b),
        .errClear     (errClear),
        .delay        (delay),
        .slip         (slip),
        .locked       (locked),
        .state        (state),
        .wordErr      (wordErr),
        .errCount     (errCount)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] rotl40(input logic [39:0] w, input int k);
        logic [79:0] dbl;
        dbl = {w, w} << k;
        return dbl[79:40];
    endfunction

    // Present one word (chosen from the current DUT delay), clock it, sample 1 ns later.
    task automatic tick();
        logic [39:0] w;
        logic        b;
        if (prbsMode) begin
            for (int k = 0; k < 40; k++) begin
                b        = prbsReg[6] ^ prbsReg[5];
                w[39-k]  = b;
                prbsReg  = {prbsReg[5:0], b};
            end
            word40b = w ^ ((int'(delay) == target) ? 40'd0 : PRBS_BAD) ^ errMask;
        end else begin
            word40b = rotl40(FIX_BASE, (40 + target - int'(delay)) % 40) ^ errMask;
        end
        @(posedge clk);
        #1;
        if (slip) slipCount++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int guard;
        int expErr;
        int pc;

        reset        = 1'b1;
        enable       = 1'b0;
        patternSel   = 1'b1;
        errClear     = 1'b0;
        fixedPattern = FIX_PAT;
        word40b      = '0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_state", state, 0);
        checkVal("rst_delay", delay, 0);
        checkVal("rst_locked", locked, 0);
        checkVal("rst_slip", slip, 0);
        checkVal("rst_worderr", wordErr, 0);
        checkVal("rst_errcount", errCount, 0);
        reset = 1'b0;

        // 1: fixed pattern, bench rotation 7 -> 7 slips, lock after 1 + 7*4 + 8 words.
        enable = 1'b1;
        tick();
        checkVal("t1_search", state, 1);
        n = 1;
        while (!locked && n < 200) begin
            tick();
            n++;
        end
        checkVal("t1_words_to_lock", n, 1 + 7 * (1 + 3) + 8);
        checkVal("t1_locked", locked, 1);
        checkVal("t1_state", state, 3);
        checkVal("t1_delay", delay, 7);
        checkVal("t1_slips", slipCount, 7);
        checkVal("t1_errcount", errCount, 0);
        checkVal("t1_worderr", wordErr, 0);

        // 2: expected pattern changes under lock; 3 counted error words, 4th drops lock.
        fixedPattern = 32'hAAAAAAAA;
        pc     = $countones(FIX_PAT ^ 32'hAAAAAAAA);
        expErr = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expErr += pc;
            checkVal("t2_worderr", wordErr, 1);
            checkVal("t2_locked", locked, 1);
            checkVal("t2_errcount", errCount, expErr);
        end
        tick();
        checkVal("t2_drop_state", state, 1);
        checkVal("t2_drop_locked", locked, 0);
        checkVal("t2_drop_slip", slip, 0);
        checkVal("t2_drop_delay", delay, 7);
        checkVal("t2_drop_errcount", errCount, expErr);

        // Restore the pattern: delay already right, so relock takes GOOD_COUNT words.
        fixedPattern = FIX_PAT;
        slipCount    = 0;
        n = 0;
        while (!locked && n < 40) begin
            tick();
            n++;
        end
        checkVal("t2_relock_words", n, 8);
        checkVal("t2_relock_slips", slipCount, 0);

        // 4: drive errCount to saturation with 3 bad + 1 good word groups.
        guard = 0;
        while (expErr != 65535 && guard < 1000) begin
            errMask = FULL_ERR;
            repeat (3) begin
                tick();
                expErr = (expErr + 32 > 65535) ? 65535 : expErr + 32;
            end
            errMask = '0;
            tick();
            guard++;
        end
        checkVal("t4_saturate", errCount, 16'hFFFF);
        checkVal("t4_locked", locked, 1);
        errMask = FULL_ERR;
        repeat (3) tick();
        errMask = '0;
        tick();
        checkVal("t4_clamp", errCount, 16'hFFFF);
        errMask  = FULL_ERR;
        errClear = 1'b1;
        tick();
        errClear = 1'b0;
        errMask  = '0;
        checkVal("t4_clear_wins", errCount, 0);
        checkVal("t4_clear_worderr", wordErr, 1);
        tick();
        checkVal("t4_clean_worderr", wordErr, 0);

        // 5: lose lock (3 counted errors), reach CONFIRM, then drop enable.
        errMask = FULL_ERR;
        repeat (4) tick();
        errMask = '0;
        checkVal("t5_search", state, 1);
        checkVal("t5_errcount", errCount, 96);
        repeat (2) tick();
        checkVal("t5_confirm", state, 2);
        enable = 1'b0;
        tick();
        checkVal("t5_idle", state, 0);
        checkVal("t5_delay_held", delay, 7);
        checkVal("t5_errcount_held", errCount, 96);
        enable = 1'b1;
        tick();
        checkVal("t5_search_again", state, 1);
        #2;
        reset = 1'b1;
        #1;
        checkVal("t5_async_state", state, 0);
        checkVal("t5_async_delay", delay, 0);
        checkVal("t5_async_errcount", errCount, 0);
        checkVal("t5_async_locked", locked, 0);
        reset = 1'b0;

`ifdef LINKCHK_PRBS7_EN
        // 3: PRBS7, target delay 39 from reset, then retarget to 0 to force the wrap.
        patternSel = 1'b0;
        prbsMode   = 1'b1;
        target     = 39;
        slipCount  = 0;
        tick();
        n = 0;
        while (!locked && n < 400) begin
            tick();
            n++;
        end
        checkVal("t3_words_to_lock", n, 39 * (1 + 3) + 8);
        checkVal("t3_delay39", delay, 39);
        checkVal("t3_slips", slipCount, 39);
        target = 0;
        repeat (4) tick();
        checkVal("t3_drop_state", state, 1);
        checkVal("t3_drop_delay", delay, 39);
        tick();
        checkVal("t3_wrap_delay", delay, 0);
        checkVal("t3_wrap_slip", slip, 1);
        n = 0;
        while (!locked && n < 40) begin
            tick();
            n++;
        end
        checkVal("t3_relock_words", n, 3 + 8);
        errClear = 1'b1;
        tick();
        errClear = 1'b0;
        checkVal("t3_cleared", errCount, 0);
        errMask = 40'h1 << 20;
        tick();
        errMask = '0;
        checkVal("t3_flip_errcount", errCount, 3);
        checkVal("t3_flip_worderr", wordErr, 1);
        checkVal("t3_flip_locked", locked, 1);
        tick();
        checkVal("t3_after_worderr", wordErr, 0);
        checkVal("t3_after_errcount", errCount, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
